image_window_ctrl: RTL
======================

IMAGE_WINDOW_CTRL -- requirements
Module: image_window_ctrl

Interface
REQ-001 SHALL have parameter LINE_W, default 512: pixels per image line.
REQ-002 SHALL have parameter NUM_LB, default 4: number of line buffers (fixed at 4 for this release).
REQ-003 SHALL have port clk  input  1: single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rstn  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_pixel  input  8: incoming pixel, raster order.
REQ-006 SHALL have port i_pixel_valid  input  1: qualifies i_pixel; one pixel is accepted per cycle while high.
REQ-007 SHALL have port o_window  output  72: 3x3 window; byte i = row r*3 + col c, where r0 is the oldest line and c0 is the leftmost column.
REQ-008 SHALL have port o_window_valid  output  1: qualifies o_window; feeds the sharpen MAC pixel_data_valid input.
REQ-009 SHALL have port o_intr  output  1: one-cycle pulse when a line buffer has been fully consumed and freed, requesting the next line from the DMA.

Function
REQ-010 SHALL write each valid pixel to lb[wr_lb][wr_ptr], then increment wr_ptr; at LINE_W-1, wr_ptr wraps to 0 and wr_lb advances modulo 4.
REQ-011 SHALL keep pix_cnt, width clog2(4*LINE_W)+1: +1 on a write, -1 on a read issue, unchanged when both occur in the same cycle.
REQ-012 SHALL implement a read FSM with states IDLE and READ; IDLE->READ when pix_cnt >= 3*LINE_W; READ->IDLE on the cycle the read at rd_ptr==LINE_W-1 is issued.
REQ-013 SHALL issue exactly one read per cycle while in READ; rd_ptr runs 0..LINE_W-1 and then wraps to 0.
REQ-014 SHALL fetch each read from line buffers rd_lb, rd_lb+1 and rd_lb+2 (mod 4) at columns x, x+1 and x+2, with each column index clamped to LINE_W-1 (right-edge replication).
REQ-015 SHALL produce LINE_W windows per line, i.e. one per read.
REQ-016 SHALL register line-buffer reads: a read issued at cycle t gives o_window and o_window_valid=1 at t+1; o_window_valid=0 otherwise, and o_window holds its last value.
REQ-017 SHALL, on the final read of a line, advance rd_lb modulo 4 and assert o_intr in the following cycle, aligned with the last o_window_valid.
REQ-018 SHALL insert exactly one IDLE cycle between consecutive lines (no window in that cycle), even when pix_cnt is still >= 3*LINE_W.
REQ-019 SHALL perform a write to lb[wr_lb] in the same cycle as a read of other buffers without conflict; the producer never writes more than 4*LINE_W unconsumed pixels (o_intr protocol), so no overflow checking is required.

Reset
REQ-020 SHALL, while rstn=0, force wr_ptr, wr_lb, rd_ptr, rd_lb and pix_cnt to 0, the FSM to IDLE, and o_window, o_window_valid and o_intr to 0.
REQ-021 SHALL, on reset during READ, abandon the partial line; after release the next pixel is written to lb0 column 0.
REQ-022 SHALL NOT reset line-buffer storage contents.

Structure
REQ-023 SHALL place LINE_W and NUM_LB defaults, the state encoding (IDLE, READ) and the window byte-index constants in the shared image-processing package.
REQ-024 SHALL use sub-module line_buffer (LINE_W x 8 storage, one write port, registered 3-pixel clamped read), instantiated 4 times.

Verification
REQ-025 SHALL pass with LINE_W=8 and pixel value = 16*line + col on the following directed scenarios.
REQ-026 Three lines fed continuously -> READ entered the cycle after the 24th write; first o_window = bytes 8..0 {22,21,20,12,11,10,02,01,00}h.
REQ-027 Same stimulus -> 8th window = {27,27,27,17,17,17,07,07,07}h; o_intr pulses once, together with that window; pix_cnt=16 afterwards.
REQ-028 Line 3 streamed during reads of lines 0..2 -> pix_cnt unchanged across simultaneous write/read cycles; one IDLE bubble, then the next line's windows (rows 1..3) with first window {32,31,30,22,21,20,12,11,10}h.
REQ-029 Six lines continuous -> writes wrap lb3->lb0 with no corruption of windows for rows 3..5; o_intr count = 4 after all reads.
REQ-030 rstn pulsed low mid-READ (rd_ptr=4) -> all outputs 0 immediately; no o_intr; a fresh 3-line feed reproduces the window sequence of REQ-026.

Source files
------------

// File: rtl/image_window_ctrl_pkg.sv
// rtl/image_window_ctrl_pkg.sv - shared image-processing constants, state encoding and window indexing
//
// Purpose : defaults for line width and line-buffer count, read FSM state
//           encoding and the byte layout of the 3x3 window bus.
// Ports   : none (package).

package image_window_ctrl_pkg;

    localparam int LINE_W_DEF = 512;
    localparam int NUM_LB_DEF = 4;

    localparam int WIN_ROWS  = 3;
    localparam int WIN_COLS  = 3;
    localparam int WIN_BYTES = WIN_ROWS * WIN_COLS;
    localparam int PIX_W     = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_t;

    // Byte index inside o_window: row 0 is the oldest line, column 0 the leftmost.
    function automatic int win_byte_idx(input int row, input int col);
        return row * WIN_COLS + col;
    endfunction

endpackage

// File: rtl/image_window_ctrl_line_buffer.sv
// rtl/image_window_ctrl_line_buffer.sv - one image line of pixel storage with a clamped 3-pixel registered read
//
// Purpose : LINE_W x 8 storage, one write port, and a registered read that
//           returns columns x, x+1, x+2 with indices clamped to LINE_W-1.
// Ports   : clk, rstn          - clock, async active-low reset (read register only)
//           i_wr_en/addr/data  - pixel write
//           i_rd_en/addr       - read request at column x
//           o_rd_data          - {col x+2, col x+1, col x}, updated only on a read

module line_buffer #(
    parameter int LINE_W = 512
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_wr_en,
    input  logic [$clog2(LINE_W)-1:0] i_wr_addr,
    input  logic [7:0]                i_wr_data,
    input  logic                      i_rd_en,
    input  logic [$clog2(LINE_W)-1:0] i_rd_addr,
    output logic [23:0]               o_rd_data
);

    localparam int AW = $clog2(LINE_W);
    localparam logic [AW-1:0] LAST_COL = AW'(LINE_W - 1);
    localparam logic [AW-1:0] PENULT   = AW'(LINE_W - 2);

    logic [7:0]    r_mem [LINE_W];
    logic [23:0]   r_rd_data;
    logic [AW-1:0] w_addr1;
    logic [AW-1:0] w_addr2;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Right-edge replication: neighbours past the last column repeat it.
    assign w_addr1 = (i_rd_addr == LAST_COL) ? LAST_COL : i_rd_addr + AW'(1);
    assign w_addr2 = (i_rd_addr >= PENULT)   ? LAST_COL : i_rd_addr + AW'(2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= {r_mem[w_addr2], r_mem[w_addr1], r_mem[i_rd_addr]};
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/image_window_ctrl.sv
// rtl/image_window_ctrl.sv - rolling four-line buffer producing 3x3 pixel windows for the sharpen MAC
//
// Purpose : stores raster pixels into four rotating line buffers and, once
//           three lines are resident, streams one 3x3 window per column.
// Ports   : clk, rstn        - clock, async active-low reset
//           i_pixel/_valid   - incoming raster pixel stream
//           o_window/_valid  - 3x3 window (byte r*3+c), one per read
//           o_intr           - pulse when a line buffer is freed (next-line request)

module image_window_ctrl
    import image_window_ctrl_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int NUM_LB = NUM_LB_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  i_pixel,
    input  logic        i_pixel_valid,
    output logic [71:0] o_window,
    output logic        o_window_valid,
    output logic        o_intr
);

    localparam int AW  = $clog2(LINE_W);
    localparam int LBW = $clog2(NUM_LB);
    localparam int CW  = $clog2(4 * LINE_W) + 1;

    localparam logic [AW-1:0]  LAST_COL  = AW'(LINE_W - 1);
    localparam logic [LBW-1:0] LAST_LB   = LBW'(NUM_LB - 1);
    localparam logic [CW-1:0]  READY_CNT = CW'(3 * LINE_W);

    rd_state_t      r_state;
    rd_state_t      w_state_nxt;

    logic [AW-1:0]  r_wr_ptr;
    logic [LBW-1:0] r_wr_lb;
    logic [AW-1:0]  r_rd_ptr;
    logic [LBW-1:0] r_rd_lb;
    logic [CW-1:0]  r_pix_cnt;
    logic [LBW-1:0] r_win_lb;
    logic           r_window_valid;
    logic           r_intr;

    logic           w_rd_issue;
    logic           w_last_rd;
    logic [23:0]    w_lb_rd_data [NUM_LB];
    logic [71:0]    w_window;

    function automatic logic [LBW-1:0] row_lb(input logic [LBW-1:0] base, input int row);
        return LBW'((int'(base) + row) % NUM_LB);
    endfunction

    assign w_rd_issue = (r_state == ST_READ);
    assign w_last_rd  = w_rd_issue && (r_rd_ptr == LAST_COL);

    // ---------------- write side ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_wr_lb  <= '0;
        end else if (i_pixel_valid) begin
            if (r_wr_ptr == LAST_COL) begin
                r_wr_ptr <= '0;
                r_wr_lb  <= (r_wr_lb == LAST_LB) ? '0 : r_wr_lb + LBW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
        end
    end

    // Unconsumed pixel count; a write and a read in the same cycle cancel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pix_cnt <= '0;
        end else begin
            case ({i_pixel_valid, w_rd_issue})
                2'b10:   r_pix_cnt <= r_pix_cnt + CW'(1);
                2'b01:   r_pix_cnt <= r_pix_cnt - CW'(1);
                default: r_pix_cnt <= r_pix_cnt;
            endcase
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // READ always drops back to IDLE after a line, giving one bubble per line.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_pix_cnt >= READY_CNT) w_state_nxt = ST_READ;
            ST_READ: if (r_rd_ptr == LAST_COL)   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_rd_lb  <= '0;
        end else if (w_rd_issue) begin
            if (w_last_rd) begin
                r_rd_ptr <= '0;
                r_rd_lb  <= (r_rd_lb == LAST_LB) ? '0 : r_rd_lb + LBW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // The oldest-line buffer of the read just issued, so the window mux
    // stays aligned with the registered line-buffer outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win_lb       <= '0;
            r_window_valid <= 1'b0;
            r_intr         <= 1'b0;
        end else begin
            if (w_rd_issue) begin
                r_win_lb <= r_rd_lb;
            end
            r_window_valid <= w_rd_issue;
            r_intr         <= w_last_rd;
        end
    end

    // ---------------- line buffers ----------------
    // All buffers are read together; the unused one is simply not selected.
    for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
        line_buffer #(
            .LINE_W (LINE_W)
        ) u_lb (
            .clk       (clk),
            .rstn      (rstn),
            .i_wr_en   (i_pixel_valid && (r_wr_lb == LBW'(g))),
            .i_wr_addr (r_wr_ptr),
            .i_wr_data (i_pixel),
            .i_rd_en   (w_rd_issue),
            .i_rd_addr (r_rd_ptr),
            .o_rd_data (w_lb_rd_data[g])
        );
    end

    always_comb begin
        w_window = '0;
        for (int r = 0; r < WIN_ROWS; r++) begin
            for (int c = 0; c < WIN_COLS; c++) begin
                w_window[win_byte_idx(r, c)*PIX_W +: PIX_W] =
                    w_lb_rd_data[row_lb(r_win_lb, r)][c*PIX_W +: PIX_W];
            end
        end
    end

    assign o_window       = w_window;
    assign o_window_valid = r_window_valid;
    assign o_intr         = r_intr;

endmodule
